// File: rtl/bb_pkg.sv
// Shared definitions for the baseball action stream, used by the play
// generator and the scoring receiver.
//   - action codes ACT_BB..ACT_FLY (3-bit)
//   - half-inning codes TOP / BOT
//   - generator state type gen_state_e
//   - default LFSR seed and Galois tap mask, plus a one-step helper
package bb_pkg;

   localparam logic [2:0] ACT_BB   = 3'd0;
   localparam logic [2:0] ACT_1H   = 3'd1;
   localparam logic [2:0] ACT_2H   = 3'd2;
   localparam logic [2:0] ACT_3H   = 3'd3;
   localparam logic [2:0] ACT_HR   = 3'd4;
   localparam logic [2:0] ACT_BUNT = 3'd5;
   localparam logic [2:0] ACT_GND  = 3'd6;
   localparam logic [2:0] ACT_FLY  = 3'd7;

   localparam logic TOP = 1'b0;
   localparam logic BOT = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      FIN  = 2'd2
   } gen_state_e;

   localparam logic [15:0] SEED_DEF  = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois step: the bit shifted out folds the taps back in.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/bb_lfsr16.sv
// 16-bit Galois LFSR used as the random action source.
//   clk      in   clock
//   rst      in   synchronous active-high reset (state -> SEED_DEF)
//   load_i   in   load seed_i; if step_i is also high the loaded value
//                 is already advanced by one step
//   seed_i   in   16-bit seed
//   step_i   in   advance one step
//   state_o  out  current LFSR state
module bb_lfsr16
   import bb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [15:0] seed_i,
   input  logic        step_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = step_i ? lfsr_next(seed_i) : seed_i;
      end else if (step_i) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED_DEF;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/bb_play_gen.sv
// Baseball play generator: emits one complete game as a gap-free stream of
// (inning, half, action) with in_valid, tracking outs and the runner on 1st
// so halves switch exactly where the scoring receiver records the 3rd out.
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle game request (honoured only when idle)
//   seed             LFSR seed latched on start (0 selects SEED_DEF)
//   ext_act_en/act   external action override
//   in_valid         high for every action of the game
//   inning, half     position of the current action
//   action           current action code
//   busy             high from accepted start until done
//   done             one-cycle pulse after the last action
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last game's values
// PLAY  | an action is on the outputs; each cycle emits the next one
// FIN   | done pulse cycle; in_valid/busy low
module bb_play_gen #(
   parameter int          N_INNING = 3,
   parameter int          MAX_PA   = 15,
   parameter logic [15:0] SEED_DEF = bb_pkg::SEED_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] seed,
   input  logic        ext_act_en,
   input  logic [2:0]  ext_act,
   output logic        in_valid,
   output logic [1:0]  inning,
   output logic        half,
   output logic [2:0]  action,
   output logic        busy,
   output logic        done
);

   import bb_pkg::*;

   localparam logic [1:0] INN_LAST = 2'(N_INNING);
   localparam logic [4:0] PA_LIM   = 5'(MAX_PA);

   gen_state_e  state_q, state_d;
   logic [1:0]  outs_q, outs_d;
   logic        base1_q, base1_d;
   logic [4:0]  pa_q, pa_d;
   logic        hend_q, hend_d;     // action on the outputs ended its half
   logic        in_valid_q, in_valid_d;
   logic [1:0]  inning_q, inning_d;
   logic        half_q, half_d;
   logic [2:0]  action_q, action_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        accept;
   logic        game_over;
   logic        emit;
   logic [15:0] seed_eff;
   logic [15:0] lfsr_state;
   logic [15:0] lfsr_cur;
   logic [2:0]  act;
   logic [1:0]  outs_n;
   logic        base1_n;
   logic        end_n;
   logic [4:0]  pa_n;
   logic [1:0]  inn_nx;
   logic        half_nx;

   assign accept    = (state_q == IDLE) && start;
   assign game_over = hend_q && (inning_q == INN_LAST) && (half_q == BOT);
   assign emit      = accept || ((state_q == PLAY) && !game_over);
   assign seed_eff  = (seed == 16'h0000) ? SEED_DEF : seed;

   // The first action of a game is drawn from the seed itself, before the
   // register has loaded it.
   assign lfsr_cur  = (state_q == IDLE) ? seed_eff : lfsr_state;

   bb_lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .seed_i  (seed_eff),
      .step_i  (emit && !ext_act_en),
      .state_o (lfsr_state)
   );

   always_comb begin
      if (pa_q >= PA_LIM) begin
         act = ACT_FLY;
      end else if (ext_act_en) begin
         act = ext_act;
      end else begin
         act = lfsr_cur[2:0];
      end
   end

   // Outs / runner bookkeeping for the action about to be emitted.
   always_comb begin
      outs_n  = outs_q;
      base1_n = base1_q;
      end_n   = 1'b0;
      unique case (act)
         ACT_BB, ACT_1H: base1_n = 1'b1;
         ACT_2H, ACT_3H, ACT_HR: base1_n = 1'b0;
         ACT_BUNT: begin
            base1_n = 1'b0;
            if (outs_q == 2'd2) end_n = 1'b1;
            else                outs_n = outs_q + 2'd1;
         end
         ACT_GND: begin
            if (outs_q == 2'd0) begin
               outs_n  = base1_q ? 2'd2 : 2'd1;
               base1_n = 1'b0;
            end else if (outs_q == 2'd1) begin
               if (base1_q) begin
                  end_n = 1'b1;
               end else begin
                  outs_n  = 2'd2;
                  base1_n = 1'b0;
               end
            end else begin
               end_n = 1'b1;
            end
         end
         ACT_FLY: begin
            if (outs_q == 2'd2) end_n = 1'b1;
            else                outs_n = outs_q + 2'd1;
         end
         default: ;
      endcase
      if (end_n) begin
         outs_n  = 2'd0;
         base1_n = 1'b0;
      end
   end

   assign pa_n = end_n ? 5'd0 : ((pa_q == 5'd31) ? pa_q : pa_q + 5'd1);

   // Position of the action about to be emitted.
   always_comb begin
      inn_nx  = inning_q;
      half_nx = half_q;
      if (accept) begin
         inn_nx  = 2'd1;
         half_nx = TOP;
      end else if (hend_q) begin
         half_nx = ~half_q;
         if (half_q == BOT) inn_nx = inning_q + 2'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      outs_d     = outs_q;
      base1_d    = base1_q;
      pa_d       = pa_q;
      hend_d     = hend_q;
      in_valid_d = in_valid_q;
      inning_d   = inning_q;
      half_d     = half_q;
      action_d   = action_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = PLAY;
               in_valid_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         PLAY: begin
            if (game_over) begin
               state_d    = FIN;
               in_valid_d = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               hend_d     = 1'b0;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (emit) begin
         action_d = act;
         inning_d = inn_nx;
         half_d   = half_nx;
         outs_d   = outs_n;
         base1_d  = base1_n;
         pa_d     = pa_n;
         hend_d   = end_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         outs_q     <= 2'd0;
         base1_q    <= 1'b0;
         pa_q       <= 5'd0;
         hend_q     <= 1'b0;
         in_valid_q <= 1'b0;
         inning_q   <= 2'd0;
         half_q     <= TOP;
         action_q   <= 3'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         outs_q     <= outs_d;
         base1_q    <= base1_d;
         pa_q       <= pa_d;
         hend_q     <= hend_d;
         in_valid_q <= in_valid_d;
         inning_q   <= inning_d;
         half_q     <= half_d;
         action_q   <= action_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_valid = in_valid_q;
   assign inning   = inning_q;
   assign half     = half_q;
   assign action   = action_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
